// File: rtl/aes_key_expand_seq.sv
// aes_key_expand_seq: sequential AES key-schedule generator.
//
// Computes one 32-bit schedule word per clock into an internal word store and
// exposes the finished schedule as 128-bit round keys through a registered,
// indexed read port.
//
// Build option:
//   AES_LONG_KEY_EN  defined   -> AES-128/192/256 selectable through key_len.
//                    undefined -> AES-128 only, 44-word store, key_len ignored.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       request expansion (honoured in IDLE only)
//   key_len     00=128, 01=192, 10=256, 11=128 (sampled with start)
//   key         cipher key, MSB-first (128-bit key in [255:128], 192-bit in [255:64])
//   busy        expansion in progress (LOAD and EXPAND)
//   done        one-cycle pulse when the schedule is complete
//   keys_valid  schedule complete and readable
//   nr          round count of the stored schedule (10, 12 or 14)
//   rk_idx      round-key index 0..nr
//   rk_data     round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, one cycle after rk_idx
module aes_key_expand_seq #(
  parameter int unsigned MAX_WORDS = 60
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  output logic [3:0]   nr,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_data
);

`ifdef AES_LONG_KEY_EN
  localparam int unsigned StoreWords = MAX_WORDS;
  localparam int unsigned ModW       = 3;
  localparam int unsigned KeyW       = 256;
  localparam int unsigned MaxNk      = 8;
`else
  localparam int unsigned StoreWords = (MAX_WORDS < 44) ? MAX_WORDS : 44;
  localparam int unsigned ModW       = 2;
  localparam int unsigned KeyW       = 128;
  localparam int unsigned MaxNk      = 4;
`endif

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StExpand,
    StDone
  } state_e;

  // GF(2^8) helpers; the S-box is computed as inverse followed by the affine map.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] aes_sbox(input logic [7:0] a);
    logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, a252, inv;
    // a^254 is the multiplicative inverse (and maps 0 to 0)
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a6   = gf_mul(a3, a3);
    a12  = gf_mul(a6, a6);
    a15  = gf_mul(a12, a3);
    a30  = gf_mul(a15, a15);
    a60  = gf_mul(a30, a30);
    a120 = gf_mul(a60, a60);
    a240 = gf_mul(a120, a120);
    a252 = gf_mul(a240, a12);
    inv  = gf_mul(a252, a2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  state_e            state_q, state_d;
  logic [KeyW-1:0]   key_q;
  logic [5:0]        i_q;
  logic [7:0]        rcon_q;
  logic [ModW-1:0]   mod_q;
  logic              keys_valid_q;
  logic [127:0]      rk_data_q;
  logic [31:0]       w_q [StoreWords];

  logic [3:0]        nk;
  logic [ModW-1:0]   mod_last;
  logic [5:0]        last_idx;
  logic              sub_mid;
  logic [31:0]       prev_word;
  logic [31:0]       old_word;
  logic [31:0]       sub_in;
  logic [31:0]       sub_out;
  logic [31:0]       temp;
  logic [31:0]       new_word;
  logic [5:0]        rd_base;

`ifdef AES_LONG_KEY_EN
  logic [3:0] nk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nk_q <= 4'd4;
    end else if (state_q == StIdle && start) begin
      case (key_len)
        2'b01:   nk_q <= 4'd6;
        2'b10:   nk_q <= 4'd8;
        default: nk_q <= 4'd4;
      endcase
    end
  end

  assign nk      = nk_q;
  assign sub_mid = (nk_q == 4'd8) && (mod_q == 3'd4);
`else
  logic unused_inputs;
  assign unused_inputs = ^{key_len, key[127:0]};
  assign nk      = 4'd4;
  assign sub_mid = 1'b0;
`endif

  assign nr       = nk + 4'd6;
  assign mod_last = ModW'(nk - 4'd1);
  // Total words T = 4*(Nk+7); the last one written is T-1
  assign last_idx = {nk + 4'd7, 2'b00} - 6'd1;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) state_d = StLoad;
      end
      StLoad: begin
        busy    = 1'b1;
        state_d = StExpand;
      end
      StExpand: begin
        busy = 1'b1;
        if (i_q == last_idx) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Schedule word datapath
  // ---------------------------------------------------------------------------
  assign prev_word = w_q[i_q - 6'd1];
  assign old_word  = w_q[i_q - {2'b00, nk}];
  // RotWord only on the i mod Nk == 0 step
  assign sub_in    = (mod_q == '0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign sub_out[8*b +: 8] = aes_sbox(sub_in[8*b +: 8]);
  end

  always_comb begin
    if (mod_q == '0) temp = sub_out ^ {rcon_q, 24'h0};
    else if (sub_mid) temp = sub_out;
    else temp = prev_word;
    new_word = old_word ^ temp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q        <= '0;
      i_q          <= '0;
      rcon_q       <= '0;
      mod_q        <= '0;
      keys_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            key_q        <= key[255 -: KeyW];
            keys_valid_q <= 1'b0;
          end
        end
        StLoad: begin
          i_q    <= {2'b00, nk};
          rcon_q <= 8'h01;
          mod_q  <= '0;
        end
        StExpand: begin
          i_q   <= i_q + 6'd1;
          mod_q <= (mod_q == mod_last) ? '0 : mod_q + 1'b1;
          if (mod_q == '0) rcon_q <= xtime(rcon_q);
        end
        StDone: begin
          keys_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Word store is deliberately not reset
  always_ff @(posedge clk) begin
    if (state_q == StLoad) begin
      for (int j = 0; j < MaxNk; j++) begin
        if (j < int'(nk)) w_q[j] <= key_q[KeyW-1-32*j -: 32];
      end
    end else if (state_q == StExpand) begin
      w_q[i_q] <= new_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered round-key read port
  // ---------------------------------------------------------------------------
  assign rd_base = {rk_idx, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_data_q <= '0;
    end else if (keys_valid_q && (rk_idx <= nr)) begin
      rk_data_q <= {w_q[rd_base], w_q[rd_base + 6'd1], w_q[rd_base + 6'd2],
                    w_q[rd_base + 6'd3]};
    end else begin
      rk_data_q <= '0;
    end
  end

  assign keys_valid = keys_valid_q;
  assign rk_data    = rk_data_q;

endmodule

// File: doc/aes_key_expand_seq.md
# aes_key_expand_seq

Sequential AES key-schedule generator covering AES-128, AES-192 and AES-256. It sits in front of the round datapath and computes one 32-bit schedule word per clock into an internal word store. The finished schedule is exposed as 128-bit round keys through an indexed, registered read port. It trades the fully unrolled combinational expander's area for a multi-cycle latency, adds run-time key-length selection, and provides a start/done handshake.

## Interface
- `MAX_WORDS`, default 60: depth of the word store, in 32-bit words. Must be ≥ 4·(Nr_max+1), which is 60 with long keys and 44 without.
- `clk`  in  1  single clock; rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request expansion. Sampled only in IDLE.
- `key_len`  in  2  key length: 00 = 128, 01 = 192, 10 = 256. Value 11 is treated as 128. Sampled with `start`.
- `key`  in  256  cipher key, MSB-first.
  - 128-bit key occupies `key[255:128]`.
  - 192-bit key occupies `key[255:64]`.
- `busy`  out  1  expansion in progress.
- `done`  out  1  one-cycle pulse when the schedule is complete.
- `keys_valid`  out  1  schedule complete and readable.
- `nr`  out  4  round count of the stored schedule: 10, 12 or 14.
- `rk_idx`  in  4  round-key index, 0..nr.
- `rk_data`  out  128  round key `{w[4r], w[4r+1], w[4r+2], w[4r+3]}`, with `w[4r]` in bits [127:96].

## Operation
- Nk = 4, 6 or 8 and Nr = Nk+6. Total words T = 4·(Nr+1), giving 44, 52 or 60.
- State machine: IDLE → LOAD → EXPAND → DONE → IDLE.
- **IDLE:** `start`=1 latches `key_len` and `key`, and clears `keys_valid`. Next state is LOAD.
- **LOAD** (1 cycle):
  - Writes `w[0..Nk-1]` from the key.
  - Sets word index i = Nk.
  - Sets `rcon` = 0x01.
- **EXPAND:** one word per cycle.
  - temp = `w[i-1]`.
  - If i mod Nk = 0: temp = SubWord(RotWord(temp)) ^ {`rcon`, 24'h0}, then `rcon` = xtime(`rcon`).
    - xtime = shift left 1; if bit 7 was set, XOR 0x1B, kept to 8 bits.
  - Else if Nk = 8 and i mod 8 = 4: temp = SubWord(temp).
  - `w[i]` = `w[i-Nk]` ^ temp; i++.
  - Leave EXPAND after writing `w[T-1]`.
- i mod Nk is tracked with a wrap counter (0..Nk-1). No divider is used.
- SubWord uses four instances of the team's byte S-box, shared across all modes.
- **DONE** (1 cycle): `done`=1 and `keys_valid` is set. Next state is IDLE.
- `start` is ignored outside IDLE.
- `keys_valid` remains 1 until the next accepted `start` or reset.

## Timing
- **Reset values:** state IDLE.
  - `busy`, `done`, `keys_valid` = 0.
  - `nr` = 10.
  - `rk_data` = 0.
  - i and `rcon` = 0.
  - The word store is not reset.
- `busy` = 1 in LOAD and EXPAND.
- **Latency:** `start` is sampled at edge 0. LOAD occurs in cycle 1. EXPAND occupies T−Nk cycles. `done` is high in cycle:
  - 42 for AES-128,
  - 48 for AES-192,
  - 54 for AES-256.
- **Read port:**
  - `rk_data` is registered from `rk_idx`, with 1-cycle latency.
  - It reads 0 when `keys_valid`=0 or `rk_idx` > `nr`.
  - Reading on the cycle `done` is high returns 0. Valid data appears from the following cycle.
- `start` on the same cycle as `done`: ignored, because the state is DONE, not IDLE.
- Reset mid-expansion: immediate return to IDLE with `keys_valid`=0. A subsequent `start` performs a clean full expansion.

## Configuration
- **`AES_LONG_KEY_EN` defined:** AES-192 and AES-256 are supported as described above.
- **`AES_LONG_KEY_EN` undefined:**
  - `key_len` is ignored; Nk = 4 and `nr` = 10 always.
  - Only `key[255:128]` is used.
  - The word store is reduced to 44 entries.
  - The Nk = 8 SubWord path and the wrap-counter widths for 6 and 8 are removed.
  - `done` is high in cycle 42.

## Test plan
- **AES-128:** key 2b7e151628aed2a6abf7158809cf4f3c, `key_len`=00.
  - `done` is high in cycle 42 and `nr`=10.
  - `rk_idx`=1 → a0fafe1788542cb123a339392a6c7605.
  - `rk_idx`=10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
- **AES-192:** key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, `key_len`=01.
  - `done` is high in cycle 48 and `nr`=12.
  - `rk_idx`=12 → e98ba06f448c773c8ecc720401002202.
- **AES-256:** key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, `key_len`=10.
  - `done` is high in cycle 54 and `nr`=14.
  - `rk_idx`=14 → fe4890d1e6188d0b046df344706c631e.
- **Handshake:**
  - `start` pulsed again at cycle 20 of an AES-128 run is ignored, and `done` still fires in cycle 42.
  - `rk_idx`=11 after an AES-128 run → 0.
- **Reset:**
  - Assert `rst_n`=0 at cycle 30 of an AES-256 run: `busy`, `done`, `keys_valid` = 0 and `rk_data` = 0 asynchronously.
  - Then `start` the AES-128 vector and check `rk_idx`=10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
